// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        funct3_q;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, done_q;

    // Operand decode for the launch cycle.
    logic            is_div, a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b, fast_result;
    logic            div_by_zero, div_ovf;

    assign is_div      = funct3[2];
    assign a_signed    = is_div ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign b_signed    = is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
    assign sign_a      = a_signed & op_a[XLEN-1];
    assign sign_b      = b_signed & op_b[XLEN-1];
    assign mag_a       = sign_a ? -op_a : op_a;
    assign mag_b       = sign_b ? -op_b : op_b;
    assign div_by_zero = is_div && (op_b == '0);
    assign div_ovf     = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    assign fast_result = funct3[1] ? (div_by_zero ? op_a : '0)
                                   : (div_by_zero ? '1 : MIN_NEG);

    // One iteration step. The accumulator holds {hi, multiplier} for multiply
    // and {remainder, dividend/quotient} for divide.
    logic [XLEN:0] hi_sum, shifted, diff;

    always_comb begin
        hi_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = acc_q[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, opnd_q};
        if (funct3_q[2]) begin
            if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else             acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_d = {hi_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the value produced by the final iteration.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod     = (sign_a_q ^ sign_b_q) ? -acc_d : acc_d;
        quo      = (sign_a_q ^ sign_b_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem      = sign_a_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        result_d = prod[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:         result_d = prod[XLEN-1:0];
            3'b100, 3'b101: result_d = quo;
            3'b110, 3'b111: result_d = rem;
            default:        result_d = prod[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !flush) begin
                        funct3_q <= funct3;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        opnd_q   <= is_div ? mag_b : mag_a;
                        acc_q    <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (div_by_zero || div_ovf) begin
                            result_q <= fast_result;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(XLEN-1)) begin
                            result_q <= result_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign stall  = (state_q == IDLE && start && !flush) || (state_q == CALC);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, latency,
// stall length, flush, ignored start, and asynchronous reset.
module tb_muldiv_sequencer;

    logic        clk, rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic        busy, done, stall;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .result(result), .busy(busy), .done(done),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        int          lat;
        int          issue;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            exp_t  e;
            string nm;
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected done: got result %0h expected no done", result);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, " result"}, {32'h0, result}, {32'h0, e.res});
                check({nm, " latency"}, 64'(cyc - e.issue), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start low.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input string nm);
        exp_t e;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        e.res = res; e.lat = lat; e.issue = cyc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        #1;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int stall_cnt;
        int done_before;
        rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset result", {32'h0, result}, 64'h0);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset done", {63'h0, done}, 64'h0);
        check("reset stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7 * -3 with stall length measurement.
        begin
            exp_t e;
            start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
            e.res = 32'hFFFF_FFEB; e.lat = 33; e.issue = cyc;
            exp_q.push_back(e);
            name_q.push_back("MUL 7*-3");
            #1 stall_cnt = int'(stall);
            repeat (40) begin
                @(negedge clk);
                start = 1'b0;
                #1 stall_cnt += int'(stall);
            end
            check("MUL stall cycles", 64'(stall_cnt), 64'd33);
            wait_done();
        end

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min");   wait_done();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max");  wait_done();
        issue(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "MULHSU -1*2");    wait_done();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2");       wait_done();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "REM -7/2");       wait_done();
        issue(3'b101, 32'd100,       32'd7,         32'd14,        33, "DIVU 100/7");     wait_done();
        issue(3'b111, 32'd100,       32'd7,         32'd2,         33, "REMU 100/7");     wait_done();
        issue(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "DIVU 5/0");       wait_done();
        issue(3'b111, 32'd5,         32'd0,         32'd5,         1,  "REMU 5/0");       wait_done();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV min/-1");     wait_done();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "REM min/-1");     wait_done();

        // Result persists after done; then flush an operation at iteration 10.
        issue(3'b101, 32'd100, 32'd7, 32'd14, 33, "DIVU before flush"); wait_done();
        check("result hold after done", {32'h0, result}, 64'd14);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush busy", {63'h0, busy}, 64'h0);
        check("flush done", {63'h0, done}, 64'h0);
        check("flush result kept", {32'h0, result}, 64'd14);
        issue(3'b000, 32'd6, 32'd7, 32'd42, 33, "MUL after flush"); wait_done();

        // Start pulsed while busy is ignored.
        done_before = done_cnt;
        issue(3'b111, 32'd100, 32'd7, 32'd2, 33, "REMU with stray start");
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("single done with stray start", 64'(done_cnt - done_before), 64'd1);

        // Flush beats start in IDLE.
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
        #1 check("flush vs start stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check("flush vs start busy", {63'h0, busy}, 64'h0);
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        done_before = done_cnt;
        start = 1'b1; funct3 = 3'b001; op_a = 32'd123; op_b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("busy before reset", {63'h0, busy}, 64'h1);
        #1 rst = 1'b1;
        #1;
        check("async reset result", {32'h0, result}, 64'h0);
        check("async reset busy", {63'h0, busy}, 64'h0);
        check("async reset done", {63'h0, done}, 64'h0);
        check("async reset stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no done after reset", 64'(done_cnt - done_before), 64'd0);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with its own controller, implementing the RV32M operations alongside the main ALU in the EX stage. The block accepts one operation per start pulse and runs a 32-step shift-add (multiply) or restoring-subtract (divide) loop. It raises a stall to the hazard unit while busy and presents a one-cycle `done` pulse with the result. Divide-by-zero and signed overflow are resolved on a fast path without iterating.

## Interface
- `XLEN`, default 32: operand/result width; the iteration count equals `XLEN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  abort current operation (pipeline flush).
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value (dividend / multiplicand).
- `op_b`  in  XLEN  rs2 value (divisor / multiplier).
- `result`  out  XLEN  registered result; valid while `done`=1.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle result-valid pulse.
- `stall`  out  1  hold the pipeline (combinational).

## Operation
- States: IDLE, CALC, DONE.
- IDLE→CALC: `start`=1.
  - On that edge, latch `funct3`, the operand magnitudes and the result sign, and clear the counter.
  - Signedness per operand:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: `op_a` signed, `op_b` unsigned.
    - Others: both unsigned.
- IDLE→DONE (fast path, divide ops only):
  - `op_b`=0: quotient = all ones; remainder = `op_a`.
  - DIV/REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC: one iteration per cycle, `XLEN` cycles. Counter is 0..XLEN-1; at XLEN-1, → DONE.
  - Multiply: 2·XLEN-bit accumulator; add the multiplicand when the current multiplier LSB = 1, then shift.
  - Divide: shift the remainder/quotient pair left 1, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- Entering DONE: the final sign fix-up is applied and `result` is registered.
  - Product negated if sign(a) XOR sign(b) for signed ops.
  - Quotient negated if sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
  - MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits.
- DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
- `start` in CALC or DONE is ignored; no queueing.
- `flush`=1 in CALC or DONE: → IDLE on the next edge, no `done`, `result` unchanged. `flush` has priority over `start` in IDLE (no launch).
- `stall` = (IDLE & `start` & !`flush`) | CALC.
- Reset: state IDLE, counter 0, `result`=0, `busy`=0, `done`=0, `stall`=0 (with `start`=0). Reset mid-operation discards the operation immediately, with no `done`.

## Timing
- Start accepted at edge E0.
- Iterative ops: iterations on edges E1..E32; `done`=1 between E32 and E33. Latency is XLEN+1 cycles from accept to `done`.
- Fast-path ops: `done`=1 between E0 and E1 (1 cycle).
- `busy` rises after E0 and falls after the DONE cycle.
- Back-to-back: the next start is accepted on the edge that leaves DONE? No. IDLE is re-entered after DONE, so the earliest next accept is one edge after DONE ends. The minimum issue interval is XLEN+2 cycles.
- `stall` is high during the accept cycle and all CALC cycles, and low in DONE, so EX advances with `result` on the same edge that ends `done`.
- `result` holds its value after `done` until the next DONE entry.

## Test plan
- MUL `op_a`=7, `op_b`=0xFFFFFFFD (-3) → `done` 33 cycles after accept, `result`=0xFFFFFFEB; `stall` high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → `result`=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with `done` one cycle after accept. DIV 0x80000000/-1 → 0x80000000; REM of the same → 0.
- `flush` at iteration 10 → IDLE next edge, no `done` pulse, `result` keeps its prior value; a fresh `start` on the following cycle completes normally.
- `rst` asserted mid-CALC → all outputs 0 asynchronously. `start` pulsed while `busy` → ignored, exactly one `done` observed.
